// File: rtl/adc_filter_pkg.sv
// Shared types and constants for the ADC sample filtering path.
package adc_filter_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } fill_state_t;

    localparam sample_t ADC_FS_POS = 16'sh7FFF;
    localparam sample_t ADC_FS_NEG = 16'sh8000;

endpackage

// File: rtl/hyst_compare.sv
// Hysteretic threshold flag: sets above THRESH_HI, clears below THRESH_LO,
// holds in between; only evaluated when update is asserted.
module hyst_compare #(
    parameter int                        DATA_W    = 16,
    parameter logic signed [DATA_W-1:0]  THRESH_HI = 16'sd20000,
    parameter logic signed [DATA_W-1:0]  THRESH_LO = 16'sd16000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     update,
    input  logic signed [DATA_W-1:0] value,
    output logic                     flag
);

    logic r_flag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (clear) begin
            r_flag <= 1'b0;
        end else if (update) begin
            if (value > THRESH_HI) begin
                r_flag <= 1'b1;
            end else if (value < THRESH_LO) begin
                r_flag <= 1'b0;
            end
        end
    end

    assign flag = r_flag;

endmodule

// File: rtl/adc_sample_filter.sv
// Moving average over 2^LOG2_DEPTH ADC samples with a sticky full-scale
// fault flag and a hysteretic near_wall indication.
module adc_sample_filter #(
    parameter int                        DATA_W     = 16,
    parameter int                        LOG2_DEPTH = 3,
    parameter logic signed [DATA_W-1:0]  THRESH_HI  = 16'sd20000,
    parameter logic signed [DATA_W-1:0]  THRESH_LO  = 16'sd16000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    output logic                     avg_valid,
    output logic signed [DATA_W-1:0] avg_data,
    output logic                     primed,
    output logic                     near_wall,
    output logic                     overrange
);

    import adc_filter_pkg::*;

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int ACC_W = DATA_W + LOG2_DEPTH;

    logic signed [DATA_W-1:0] r_window [DEPTH];
    logic [LOG2_DEPTH-1:0]    r_wr_ptr;
    logic [LOG2_DEPTH-1:0]    r_fill_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_avg_valid;
    logic signed [DATA_W-1:0] r_avg_data;
    logic                     r_overrange;
    fill_state_t              r_state;
    fill_state_t              w_state_next;

    logic                     w_accept;
    logic                     w_last_fill;
    logic                     w_fire;
    logic                     w_full_scale;
    logic signed [ACC_W-1:0]  w_new_ext;
    logic signed [ACC_W-1:0]  w_old_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [DATA_W-1:0] w_avg_next;
    logic                     w_near_wall;

    assign w_accept     = sample_valid && !clear;
    assign w_last_fill  = (r_state == S_FILL) && (r_fill_cnt == '1);
    assign w_fire       = w_accept && ((r_state == S_RUN) || w_last_fill);
    assign w_full_scale = (sample_data == ADC_FS_POS) || (sample_data == ADC_FS_NEG);

    // The slot being overwritten holds the oldest sample once the window is full.
    assign w_new_ext  = {{LOG2_DEPTH{sample_data[DATA_W-1]}}, sample_data};
    assign w_old_ext  = (r_state == S_RUN)
                      ? {{LOG2_DEPTH{r_window[r_wr_ptr][DATA_W-1]}}, r_window[r_wr_ptr]}
                      : '0;
    assign w_acc_next = r_acc + w_new_ext - w_old_ext;
    assign w_avg_next = DATA_W'(w_acc_next >>> LOG2_DEPTH);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL:  if (w_accept && w_last_fill) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_FILL;
        endcase
        if (clear) begin
            w_state_next = S_FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_avg_valid <= 1'b0;
            r_avg_data  <= '0;
            r_overrange <= 1'b0;
        end else if (clear) begin
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_avg_valid <= 1'b0;
            r_avg_data  <= '0;
            r_overrange <= 1'b0;
        end else begin
            r_avg_valid <= w_fire;
            if (w_accept) begin
                r_acc    <= w_acc_next;
                r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
                if (r_state == S_FILL) begin
                    r_fill_cnt <= r_fill_cnt + LOG2_DEPTH'(1);
                end
                if (w_full_scale) begin
                    r_overrange <= 1'b1;
                end
            end
            if (w_fire) begin
                r_avg_data <= w_avg_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_window[r_wr_ptr] <= sample_data;
        end
    end

    hyst_compare #(
        .DATA_W    (DATA_W),
        .THRESH_HI (THRESH_HI),
        .THRESH_LO (THRESH_LO)
    ) u_near_wall (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .update (w_fire),
        .value  (w_avg_next),
        .flag   (w_near_wall)
    );

    assign avg_valid = r_avg_valid;
    assign avg_data  = r_avg_data;
    assign primed    = (r_state == S_RUN);
    assign near_wall = w_near_wall;
    assign overrange = r_overrange;

endmodule

// File: tb/tb_adc_sample_filter.sv
// Scoreboard bench for adc_sample_filter with a 4-deep window and
// thresholds 1000/800; expected averages are hand-computed.
module tb_adc_sample_filter;

    logic                clk          = 1'b0;
    logic                reset        = 1'b1;
    logic                clear        = 1'b0;
    logic                sample_valid = 1'b0;
    logic signed [15:0]  sample_data  = '0;
    logic                avg_valid;
    logic signed [15:0]  avg_data;
    logic                primed;
    logic                near_wall;
    logic                overrange;

    always #5 clk = ~clk;

    adc_sample_filter #(
        .DATA_W     (16),
        .LOG2_DEPTH (2),
        .THRESH_HI  (16'sd1000),
        .THRESH_LO  (16'sd800)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .avg_valid    (avg_valid),
        .avg_data     (avg_data),
        .primed       (primed),
        .near_wall    (near_wall),
        .overrange    (overrange)
    );

    typedef struct {
        int avg;
        int nw;
        int ovr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int av, input int ad,
                                 input int pr, input int nw, input int ov);
        chk({tag, ".avg_valid"}, int'(avg_valid), av);
        chk({tag, ".avg_data"},  int'(avg_data),  ad);
        chk({tag, ".primed"},    int'(primed),    pr);
        chk({tag, ".near_wall"}, int'(near_wall), nw);
        chk({tag, ".overrange"}, int'(overrange), ov);
    endtask

    task automatic send(input int v, input bit fire, input int avg = 0,
                        input int nw = 0, input int ovr = 0);
        exp_t e;
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_data  = 16'(v);
        if (fire) begin
            e.avg = avg;
            e.nw  = nw;
            e.ovr = ovr;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            clear        = 1'b0;
        end
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: every avg_valid strobe must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (avg_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_avg_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb.avg_data",  int'(avg_data),  e.avg);
                    chk("sb.primed",    int'(primed),    1);
                    chk("sb.near_wall", int'(near_wall), e.nw);
                    chk("sb.overrange", int'(overrange), e.ovr);
                end
            end
        end
    end

    initial begin
        #2;
        check_outputs("in_reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: reset mid-window discards the partial fill
        send(5, 0);
        send(7, 0);
        #3;
        reset = 1'b1;
        #1;
        sample_valid = 1'b0;
        check_outputs("reset_mid", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(10, 0); send(10, 0); send(10, 0); send(10, 1, 10);
        idle(2);
        chk("primed_after_fill", int'(primed), 1);

        // 2: basic average and sliding
        do_clear();
        check_outputs("clear_primed", 0, 0, 0, 0, 0);
        send(100, 0); send(200, 0); send(300, 0); send(400, 1, 250);
        send(500, 1, 350);
        idle(2);
        chk("primed_hold", int'(primed), 1);

        // 3: negative averages floor toward minus infinity
        do_clear();
        send(-3, 0); send(-3, 0); send(-3, 0); send(-2, 1, -3);
        send(-2, 1, -3); send(-2, 1, -3); send(-2, 1, -2);
        idle(2);

        // 4: hysteresis, strictly-greater / strictly-less boundaries
        do_clear();
        send(900, 0); send(900, 0); send(900, 0); send(900, 1, 900, 0);
        send(1100, 1, 950, 0); send(1100, 1, 1000, 0);
        send(1100, 1, 1050, 1); send(1100, 1, 1100, 1);
        send(900, 1, 1050, 1); send(900, 1, 1000, 1);
        send(900, 1, 950, 1);  send(900, 1, 900, 1);
        send(700, 1, 850, 1);  send(700, 1, 800, 1);
        send(700, 1, 750, 0);  send(700, 1, 700, 0);
        idle(2);
        chk("near_wall_low", int'(near_wall), 0);

        // 5: positive full scale is sticky and still averaged
        send(32767, 1, 8716, 1, 1);
        send(700, 1, 8716, 1, 1); send(700, 1, 8716, 1, 1);
        send(700, 1, 8716, 1, 1); send(700, 1, 700, 0, 1);
        idle(2);
        chk("overrange_sticky", int'(overrange), 1);
        do_clear();
        check_outputs("clear_ovr", 0, 0, 0, 0, 0);

        // 6: clear wins over a coincident sample
        send(40, 0); send(40, 0); send(40, 0); send(40, 1, 40);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_data  = 16'sd123;
        clear        = 1'b1;
        @(posedge clk);
        #1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        check_outputs("clear_with_sample", 0, 0, 0, 0, 0);
        send(8, 0); send(8, 0); send(8, 0); send(8, 1, 8);
        send(-32768, 1, -8186, 0, 1);
        idle(2);

        // asynchronous reset while primed and flagged
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs("reset_primed", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        chk("pending_expectations", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_sample_filter.md
Name: adc_sample_filter

Overview:
- Downstream consumer of the ADC sample stream produced by the I2C ADC polling stage. That stage reads the 16-bit conversion register of the slave at 0x48.
- This block takes each completed sample, keeps a moving average over 2^LOG2_DEPTH samples, and flags range faults.
- It drives a hysteretic near_wall flag that the wall-follower PID stage and the status LEDs consume.

Parameters:
- DATA_W, 16, sample and average width, two's complement.
- LOG2_DEPTH, 3, log2 of the averaging window (depth 8). Legal range 1..6.
- THRESH_HI, 16'sd20000, signed; near_wall sets when the new average is strictly greater than this value.
- THRESH_LO, 16'sd16000, signed; near_wall clears when the new average is strictly less than this value. THRESH_LO must not exceed THRESH_HI.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- clear, input, 1, synchronous flush of window, state and sticky flags.
- sample_valid, input, 1, one-cycle strobe: sample_data holds a new conversion.
- sample_data, input, DATA_W, signed ADC sample, high byte first as read from the ADC.
- avg_valid, output, 1, one-cycle strobe: avg_data updated.
- avg_data, output, DATA_W, signed moving average.
- primed, output, 1, high once the window holds DEPTH samples.
- near_wall, output, 1, hysteretic threshold flag.
- overrange, output, 1, sticky; set by a full-scale sample.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. During reset every output reads 0, and the accumulator, write pointer, fill counter and state are 0 / S_FILL. Window storage is not reset.
- State machine, 2 states:
  - S_FILL: the counter counts accepted samples. On the DEPTH-th sample go to S_RUN and set primed in the same cycle.
  - S_RUN: stays until reset or clear.
- Per accepted sample (sample_valid=1, clear=0):
  - window[wr_ptr] <= sample_data; wr_ptr increments modulo DEPTH.
  - acc_next = acc + sample_data - (S_RUN ? window[wr_ptr] : 0). The old entry is read before the write.
  - acc is signed, DATA_W+LOG2_DEPTH bits wide, with no saturation; overflow is impossible by width.
- Output timing:
  - avg_data <= acc_next >>> LOG2_DEPTH, an arithmetic shift (floor, rounds toward minus infinity), truncated to DATA_W.
  - avg_valid pulses 1 cycle after sample_valid, only when the sample completes or follows priming: the DEPTH-th sample and every one after it. Latency is 1 clk.
  - No avg_valid pulses during S_FILL before the DEPTH-th sample; avg_data holds its last value, which is 0 after reset or clear.
- near_wall: evaluated on the new average in the same cycle avg_valid asserts.
  - Set if avg > THRESH_HI; clear if avg < THRESH_LO; otherwise hold.
  - Unchanged when no avg_valid occurs.
- overrange: set when an accepted sample equals 16'sh7FFF or 16'sh8000. Sticky until clear or reset. The sample is still averaged.
- Throughput: sample_valid may assert every cycle; there is no backpressure and every strobe is consumed.
- clear together with sample_valid: clear wins and the sample is dropped. Next cycle:
  - acc, wr_ptr, counter, primed, near_wall, overrange and avg_data are 0, state is S_FILL;
  - avg_valid is 0.
- Reset asserted mid-window: everything returns to reset values immediately; the partial window is discarded.

Decomposition:
- Package adc_filter_pkg:
  - DATA_W constant and the sample_t typedef (signed logic [DATA_W-1:0]);
  - fill_state_t enum {S_FILL, S_RUN};
  - full-scale constants ADC_FS_POS = 16'sh7FFF and ADC_FS_NEG = 16'sh8000.
- One sub-module, hyst_compare: inputs clk, reset, clear, update, value, and THRESH_HI/THRESH_LO parameters; output flag. It implements the near_wall rule and is reusable for the other distance channels.

Test Plan (LOG2_DEPTH=2, THRESH_HI=1000, THRESH_LO=800):
1. Assert reset mid-stream after 2 samples -> all outputs 0 at once; next 4 samples of 10 -> first avg_valid on the 4th, avg_data=10.
2. Samples 100,200,300,400 -> no avg_valid on the first three; 1 cycle after the 4th, avg_valid=1, avg_data=250, primed=1. Then sample 500 -> avg_data=350.
3. Samples -3,-3,-3,-2 -> avg_data=-3 (sum -11, floor of -2.75). Then -2,-2,-2 -> -2.
4. Window at 900 (4x900) -> near_wall=0. 4x1100 -> 1. 4x900 -> stays 1. 4x700 -> 0. Sample strobes on back-to-back cycles throughout.
5. Sample 16'sh7FFF -> overrange=1 and stays after further normal samples. Pulse clear -> overrange=0.
6. clear and sample_valid in the same cycle while primed -> no avg_valid, primed=0, avg_data=0. The next 3 samples produce no avg_valid; the 4th produces one.
